// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: 8N1 UART transmitter on the picorv32 native memory bus.
// Firmware pushes bytes into a TX FIFO (TXDATA), polls STATUS and sets the
// baud divider (DIV). Wait states are real: a push into a full FIFO stalls
// mem_ready until the serializer frees a slot.
//
// Bus handshake: a request is pending while sel=1 and mem_ready=0. The block
// answers a pending request with a registered, single-cycle mem_ready pulse
// (mem_rdata valid only in that cycle, 0 otherwise). Because a request is only
// pending while mem_ready=0, two acks can never occur back to back, so the
// processor drops mem_valid after the ack without a second one.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DIV_RST = 16'(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Registered state
    state_t          state_q, state_d;
    logic [15:0]     baud_cnt_q, baud_cnt_d;
    logic [15:0]     lat_div_q, lat_div_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [15:0]     div_q, div_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic            pending;
    logic            is_read;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            busy;
    logic [15:0]     div_eff;
    logic [4:0]      count_ext;
    logic [31:0]     status_w;
    logic [31:0]     rd_mux;
    logic            unused_bits;

    assign sel        = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign mem_ready  = ready_q;
    assign mem_rdata  = rdata_q;
    assign uart_tx    = tx_q;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
    assign count_ext  = 5'(count_q);
    assign status_w   = {23'd0, count_ext, 1'b0, busy, fifo_empty, fifo_full};

    // Address bits below word granularity and upper write data are don't-care
    assign unused_bits = ^{mem_wdata[31:16], mem_addr[1:0]};

    // Bus decode: ack generation, read mux, DIV register, FIFO push request
    always_comb begin
        pending  = sel && !ready_q;
        is_read  = (mem_wstrb == 4'b0000);
        push_req = pending && (mem_addr[3:2] == 2'd0) && mem_wstrb[0];
        push     = push_req && !fifo_full;
        ready_d  = pending && (!push_req || !fifo_full);

        rd_mux = 32'd0;
        case (mem_addr[3:2])
            2'd1:    rd_mux = status_w;
            2'd2:    rd_mux = {16'h0000, div_q};
            default: rd_mux = 32'd0;
        endcase

        rdata_d = (ready_d && is_read) ? rd_mux : 32'd0;

        div_d = div_q;
        if (ready_d && !is_read && (mem_addr[3:2] == 2'd2)) begin
            div_d = mem_wdata[15:0];
        end
    end

    // Serializer next-state: frame sequencing, baud counting, FIFO pop
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        lat_div_d  = lat_div_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_mem_q[rd_ptr_q];
                    lat_div_d  = div_eff;
                    baud_cnt_d = div_eff - 16'd1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == 16'd0) begin
                    state_d    = S_DATA;
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = lat_div_q - 16'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_cnt_q == 16'd0) begin
                    baud_cnt_d = lat_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle gap after the stop bit
                        pop        = 1'b1;
                        shift_d    = fifo_mem_q[rd_ptr_q];
                        lat_div_d  = div_eff;
                        baud_cnt_d = div_eff - 16'd1;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered, so uart_tx is a clean flop
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            lat_div_q  <= 16'd1;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            div_q      <= DIV_RST;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            lat_div_q  <= lat_div_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            div_q      <= div_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio: bus handshake, register decode,
// frame waveforms, back-to-back frames, FIFO backpressure and reset abort.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        sel;
    logic        uart_tx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         mon_en = 1'b0;
    int         mon_div = 100;
    int         stop_err = 0;
    logic [7:0] mon_byte;

    uart_tx_mmio #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (434),
        .FIFO_DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .sel      (sel),
        .uart_tx  (uart_tx)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serial receiver: decodes frames at bit centres while enabled
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    mon_byte[i] = uart_tx;
                end
                repeat (mon_div) @(negedge clk);
                if (uart_tx !== 1'b1) stop_err++;
                rx_q.push_back(mon_byte);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; returns in the ack cycle (#1 after the edge)
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int max_wait,
                       output int lat, output logic [31:0] rdata, output logic sel_seen);
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        #1 sel_seen = sel;
        lat = -1;
        rdata = 32'hxxxx_xxxx;
        for (int i = 1; i <= max_wait; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                rdata = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input string tag);
        int lat;
        logic [31:0] rd;
        logic s;
        bus(addr, data, strb, 4, lat, rd, s);
        check({tag, "_lat"}, lat, 32'd1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int lat;
        logic [31:0] d;
        logic s;
        bus(addr, 32'd0, 4'd0, 4, lat, d, s);
        check({tag, "_lat"}, lat, 32'd1);
        check(tag, d, exp);
    endtask

    // Compares uart_tx over frame offsets first..last; pat bit k covers offsets [k*div, (k+1)*div)
    task automatic sample_wave(input logic [63:0] pat, input int first, input int last,
                               input int div, output int bad);
        bad = 0;
        for (int off = first; off <= last; off++) begin
            if (uart_tx !== pat[off / div]) bad++;
            if (off < last) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int          bad;
        int          lat;
        int          cnt;
        logic [31:0] d;
        logic        s;
        logic [7:0]  tbl [10];

        tbl = '{8'h3C, 8'hC3, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h7E, 8'h81};

        // Reset and status
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_tx", uart_tx, 32'd1);
        check("rst_ready", mem_ready, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        bus(BASE + 32'h4, 32'd0, 4'd0, 4, lat, d, s);
        check("rst_status_sel", s, 32'd1);
        check("rst_status_lat", lat, 32'd1);
        check("rst_status", d, 32'h0000_0002);
        rd(BASE + 32'h8, 32'd434, "rst_div");

        // Valid held through the ack: exactly one ack pulse
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = BASE + 32'h4; mem_wstrb = 4'd0;
        @(posedge clk); #1;
        check("hold_ack1", mem_ready, 32'd1);
        @(posedge clk); #1;
        check("hold_ack2", mem_ready, 32'd0);
        mem_valid = 1'b0;

        // Single byte 0xA5 at DIV=4
        wr(BASE + 32'h8, 32'd4, 4'hF, "div4");
        rd(BASE + 32'h8, 32'd4, "div4_rb");
        wr(BASE, 32'h0000_00A5, 4'h1, "push_a5");
        @(posedge clk); #1;
        sample_wave(64'b1101001010, 0, 39, 4, bad);
        check("a5_wave", bad, 32'd0);
        @(posedge clk); #1;
        check("a5_idle", uart_tx, 32'd1);
        rd(BASE + 32'h4, 32'h0000_0002, "a5_status");

        // Back-to-back frames 0x00, 0xFF at DIV=2 (start bit of the first is offset 0)
        wr(BASE + 32'h8, 32'd2, 4'h3, "div2");
        wr(BASE, 32'h0000_0000, 4'h1, "push_00");
        wr(BASE, 32'h0000_00FF, 4'h1, "push_ff");
        sample_wave({44'd0, 10'b1111111110, 10'b1000000000}, 1, 39, 2, bad);
        check("b2b_wave", bad, 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) bad++;
        end
        check("b2b_idle", bad, 32'd0);

        // Full-FIFO backpressure at DIV=100
        wr(BASE + 32'h8, 32'd100, 4'hF, "div100");
        mon_div = 100;
        rx_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wr(BASE, {24'd0, tbl[k]}, 4'h1, "bp_push");
            exp_q.push_back(tbl[k]);
        end
        rd(BASE + 32'h4, 32'h0000_0085, "bp_status_full");
        bus(BASE, {24'd0, tbl[9]}, 4'h1, 3000, lat, d, s);
        exp_q.push_back(tbl[9]);
        check("bp_stall_lat", lat, 32'd983);
        rd(BASE + 32'h4, 32'h0000_0085, "bp_status_refill");
        cnt = 0;
        while (rx_q.size() < 10 && cnt < 12000) begin
            @(posedge clk);
            cnt++;
        end
        check("bp_rx_count", rx_q.size(), 32'd10);
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            check("bp_byte", rx_q.pop_front(), exp_q.pop_front());
        end
        check("bp_stop_bits", stop_err, 32'd0);
        mon_en = 1'b0;
        repeat (60) @(posedge clk);
        rd(BASE + 32'h4, 32'h0000_0002, "bp_status_done");

        // Address decode, reserved register, DIV=0
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 32'h2000_0000; mem_wstrb = 4'd0;
        #1 check("other_sel", sel, 32'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_ready) cnt++;
        end
        check("other_no_ready", cnt, 32'd0);
        mem_valid = 1'b0;
        bus(BASE + 32'hC, 32'd0, 4'd0, 4, lat, d, s);
        check("resv_sel", s, 32'd1);
        check("resv_lat", lat, 32'd1);
        check("resv_rd", d, 32'd0);
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, "resv_wr");
        rd(BASE + 32'h8, 32'd100, "resv_div_kept");
        rd(BASE, 32'd0, "txdata_rd");
        wr(BASE + 32'h8, 32'd0, 4'hF, "div0");
        rd(BASE + 32'h8, 32'd0, "div0_rb");
        wr(BASE, 32'h0000_005A, 4'h1, "push_5a");
        @(posedge clk); #1;
        sample_wave(64'b1010110100, 0, 9, 1, bad);
        check("div0_wave", bad, 32'd0);
        @(posedge clk); #1;
        check("div0_idle", uart_tx, 32'd1);

        // DIV change mid-frame only affects the next frame
        wr(BASE + 32'h8, 32'd3, 4'hF, "div3");
        wr(BASE, 32'h0000_000F, 4'h1, "push_0f");
        wr(BASE + 32'h8, 32'd5, 4'hF, "div5_mid");
        sample_wave(64'b1000011110, 1, 29, 3, bad);
        check("div3_wave", bad, 32'd0);
        rd(BASE + 32'h8, 32'd5, "div5_rb");

        // Reset during DATA with a byte still queued
        wr(BASE, 32'h0000_0033, 4'h1, "push_33");
        wr(BASE, 32'h0000_0044, 4'h1, "push_44");
        sample_wave(64'b1001100110, 1, 39, 5, bad);
        check("div5_wave", bad, 32'd0);
        @(posedge clk); #1;
        check("pre_reset_low", uart_tx, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_tx_high", uart_tx, 32'd1);
        rd(BASE + 32'h8, 32'd434, "reset_div");
        rd(BASE + 32'h4, 32'h0000_0002, "reset_status");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) cnt++;
        end
        check("reset_no_output", cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that responds on the picorv32 native memory bus (mem_valid/mem_ready), the responder side of the processor's bus. Firmware writes bytes into an internal FIFO, polls a status register and sets a baud divider. The block serializes each byte as 8N1 on `uart_tx`. It sits beside the memory in the top level: its `sel` output steers `mem_ready`/`mem_rdata` muxing, and it applies real wait states instead of a constant-ready bus.

## Interface
- `BASE_ADDR`, 32'h1000_0000, base of the 16-byte register window; bits [3:0] are ignored.
- `CLK_DIV`, 434, reset value of the baud divider, in clock cycles per bit.
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of two, from 2 to 16.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  bus request from the processor.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write strobes; 4'b0000 means a read.
- `mem_ready`  out  1  one-cycle acknowledge.
- `mem_rdata`  out  32  read data; valid while `mem_ready`=1, otherwise 0.
- `sel`  out  1  combinational: `mem_valid` & (`mem_addr`[31:4] == `BASE_ADDR`[31:4]).
- `uart_tx`  out  1  serial line; idles high.

## Operation
- **Registers** (decoded by `mem_addr`[3:2]):
  - 0x0 TXDATA, write-only. A write with `mem_wstrb`[0]=1 pushes `mem_wdata`[7:0]. Reads return 0.
  - 0x4 STATUS, read-only. Bit0 full, bit1 empty, bit2 busy (serializer not IDLE). Bits [8:4] hold the FIFO count; all other bits are 0.
  - 0x8 DIV, read/write. Any nonzero strobe loads `mem_wdata`[15:0]; reads return {16'h0, div}. A value of 0 is treated as 1.
  - 0xC reserved. Reads return 0; writes are ignored.
- **Bus handshake:**
  - A request is pending when `sel`=1 and `mem_ready`=0.
  - `mem_ready` is registered and pulses high for exactly one cycle.
  - `mem_ready` is never asserted in two consecutive cycles, so the processor drops `mem_valid` after the ack without a second ack.
  - Reads, DIV writes, reserved accesses, and TXDATA writes with `mem_wstrb`[0]=0 are acked in the cycle after they are first seen.
  - A TXDATA push is acked in the first cycle after a sampled edge at which count < `FIFO_DEPTH`. The push happens at that same edge. While the FIFO is full, `mem_ready` stays 0 (backpressure stall).
  - If `sel`=0, the block never asserts `mem_ready`.
- **Serializer FSM:** IDLE -> START -> DATA -> STOP -> IDLE.
  - In IDLE with the FIFO not empty: pop the head, latch the byte and the current div, go to START.
  - START drives 0 for div cycles.
  - DATA drives bits 0 through 7, LSB first, div cycles each, using a 3-bit bit index.
  - STOP drives 1 for div cycles.
  - Leaving STOP: go straight to START if the FIFO is not empty (back-to-back frames, no idle gap); otherwise go to IDLE.
- **Counters:** the baud counter is 16 bits and counts latched_div-1 down to 0. A DIV write during a frame affects only the next frame.
- **FIFO:** circular, with log2(DEPTH)-bit pointers that wrap, plus a separate count.
  - Simultaneous push and pop leaves the count unchanged.
  - A push into a full FIFO cannot occur, because the stall prevents it.

## Timing
- **Reset values:** `mem_ready`=0, `mem_rdata`=0, `uart_tx`=1, FSM=IDLE, count=0, pointers=0, div=`CLK_DIV`.
- **Reset mid-frame:** the FSM aborts, `uart_tx` returns to 1 on the next cycle, and FIFO contents are discarded.
- **Read latency:** `mem_valid` high in cycle N gives `mem_ready`=1 with data in cycle N+1.
- **Write latency:** with the FIFO not full, `mem_ready` rises in cycle N+1.
- **First frame:** when a push lands in an IDLE, empty FIFO at the end of cycle N+1, the start bit appears on `uart_tx` at cycle N+2 at the latest. A frame lasts 10×div cycles.
- **Full-FIFO stall:** `mem_ready` rises in the cycle after the pop edge frees a slot.

## Test plan
- **Reset and status:** assert `reset` for 3 cycles, then read 0x4. Expect `uart_tx`=1, `mem_ready` 1 cycle after the request, and rdata=32'h0000_0002.
- **Single byte:** write DIV=4, then write 0xA5 to 0x0. Expect 40 cycles on `uart_tx` of 0,1,0,1,0,0,1,0,1,1 (4 cycles each), then idle high; STATUS busy=0 afterwards.
- **Back-to-back frames:** with DIV=2, push 0x00 then 0xFF. Expect exactly 40 cycles total, with no high gap between the stop bit and the next start bit.
- **Full-FIFO backpressure:** with DIV=100, push 10 bytes (DEPTH=8).
  - The 10th push stalls `mem_ready` until the second pop.
  - All bytes appear in order.
  - STATUS reads full=1 and count=8 while stalled.
- **Address decode:** access 0x2000_0000. Expect `sel`=0 and no `mem_ready`. Read 0xC and expect 0. Write DIV=0 and expect 1-cycle bits.
- **Reset mid-frame and DIV change mid-frame:** a DIV write during a frame keeps the current bit width and applies only to the next frame. A reset pulse during DATA sends `uart_tx` to 1 next cycle, with count=0 and no further output.
